// File: rtl/hazard_sched_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sched_unit_if
// Description : Signal bundle between the pipeline datapath and the hazard
//               scheduling unit. Optional perf-counter outputs appear only
//               when HAZARD_PERF_CNT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_sched_unit_if;
  logic [4:0] Rs1D;
  logic [4:0] Rs2D;
  logic [4:0] Rs1E;
  logic [4:0] Rs2E;
  logic [4:0] RdE;
  logic [1:0] resultSrcE;
  logic       regWriteM;
  logic       regWriteW;
  logic [4:0] RdM;
  logic [4:0] RdW;
  logic       pcSrcE;
  logic       mdStartE;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       flushD;
  logic       flushE;
  logic       flushM;
  logic [1:0] forwardAE;
  logic [1:0] forwardBE;
  logic       mdBusy;
  logic       mdDone;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stallCycles;
  logic [31:0] flushCycles;
`endif

  // Datapath side: supplies pipeline-register fields, consumes controls.
  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, regWriteM, regWriteW,
           RdM, RdW, pcSrcE, mdStartE,
    input  stallF, stallD, stallE, flushD, flushE, flushM, forwardAE,
           forwardBE, mdBusy, mdDone
`ifdef HAZARD_PERF_CNT_EN
    , input stallCycles, flushCycles
`endif
  );

  // Hazard unit side.
  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, resultSrcE, regWriteM, regWriteW,
           RdM, RdW, pcSrcE, mdStartE,
    output stallF, stallD, stallE, flushD, flushE, flushM, forwardAE,
           forwardBE, mdBusy, mdDone
`ifdef HAZARD_PERF_CNT_EN
    , output stallCycles, flushCycles
`endif
  );
endinterface
`default_nettype wire

// File: rtl/hazard_sched_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_sched_unit
// Description : Hazard controller for the 5-stage pipeline: EX forwarding
//               selects, load-use stall, branch flush and a fixed-latency
//               mul/div hold sequencer. Optional stall/flush cycle counters
//               are enabled by defining HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_sched_unit #(
  parameter int MD_LATENCY = 4,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  hazard_sched_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] C_MD_LOAD = CNT_W'(MD_LATENCY - 3);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_md_hold;
  logic             w_md_done;
  logic             w_lw_stall;
  logic             w_stall_fd;
  logic             w_flush_e;
  logic             w_flush_d;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // MEM result has priority over WB; x0 is never forwarded.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                         input logic       we_m,
                                         input logic [4:0] rd_m,
                                         input logic       we_w,
                                         input logic [4:0] rd_w);
    if (we_m && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Operand forwarding selects for both ALU inputs.
  always_comb begin
    w_fwd_a = fwd_sel(bus.Rs1E, bus.regWriteM, bus.RdM, bus.regWriteW, bus.RdW);
    w_fwd_b = fwd_sel(bus.Rs2E, bus.regWriteM, bus.RdM, bus.regWriteW, bus.RdW);
  end

  // Load in EX whose destination feeds the instruction in ID.
  always_comb begin
    w_lw_stall = (bus.resultSrcE == 2'b01) && (bus.RdE != 5'd0) &&
                 ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));
  end

  // Mul/div sequencer state and down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Sequencer next-state and hold/done decode. The start cycle itself holds,
  // so the op spends 1 IDLE + (MD_LATENCY-2) BUSY + 1 DONE cycles in EX.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_md_hold   = 1'b0;
    w_md_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mdStartE) begin
          w_md_hold   = 1'b1;
          w_state_nxt = ST_BUSY;
          w_cnt_nxt   = C_MD_LOAD;
        end
      end
      ST_BUSY: begin
        w_md_hold = 1'b1;
        if (r_cnt == '0)
          w_state_nxt = ST_DONE;
        else
          w_cnt_nxt = r_cnt - CNT_W'(1);
      end
      ST_DONE: begin
        // The finishing op is still in EX, so its mdStartE must not retrigger.
        w_md_done   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Stall/flush combine; a held EX is never cleared by a flush.
  always_comb begin
    w_stall_fd = w_lw_stall | w_md_hold;
    w_flush_d  = bus.pcSrcE & ~w_md_hold;
    w_flush_e  = (w_lw_stall | bus.pcSrcE) & ~w_md_hold;
  end

  // All outputs are forced low while reset is asserted.
  assign bus.stallF    = ~rst & w_stall_fd;
  assign bus.stallD    = ~rst & w_stall_fd;
  assign bus.stallE    = ~rst & w_md_hold;
  assign bus.flushD    = ~rst & w_flush_d;
  assign bus.flushE    = ~rst & w_flush_e;
  assign bus.flushM    = ~rst & w_md_hold;
  assign bus.forwardAE = rst ? 2'b00 : w_fwd_a;
  assign bus.forwardBE = rst ? 2'b00 : w_fwd_b;
  assign bus.mdBusy    = ~rst & w_md_hold;
  assign bus.mdDone    = ~rst & w_md_done;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  // Free-running stall/flush cycle counters, wrapping at 2^32.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (w_stall_fd) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_flush_e)  r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign bus.stallCycles = r_stall_cycles;
  assign bus.flushCycles = r_flush_cycles;
`endif

endmodule
`default_nettype wire
